// File: rtl/pmm_scan_ctrl.sv
// Purpose: sequences the payload matching engine for one AXI4-Stream tap. Header beats are skipped and payload beats are framed with SOP/EOP. Rule-ID reports are collected and one verdict is emitted per packet.
// Latency: a payload beat reaches payload_in one cycle after it is accepted. The verdict is issued on pmm_done, or after TIMEOUT_CYCLES cycles in WAIT.
// Backpressure: s_axis_tready drops while a payload beat meets pmm_ready=0 and while a verdict is pending. The verdict is held until verdict_ready.
// Optional feature: define PMM_SCAN_STATS_EN to enable the stat_* counters; otherwise those ports are tied to 0.
module pmm_scan_ctrl #(
    parameter int C_S_AXIS_DATA_WIDTH = 256,
    parameter int RULE_ID_WIDTH       = 16,
    parameter int HDR_CNT_WIDTH       = 4,
    parameter int MATCH_CNT_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES      = 1024
) (
    input  logic                           axi_aclk,
    input  logic                           axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic                           s_axis_tlast,
    input  logic                           pmm_ready,
    output logic [C_S_AXIS_DATA_WIDTH-1:0] payload_in,
    output logic                           payload_valid,
    output logic                           start_of_packet,
    output logic                           end_of_packet,
    input  logic [RULE_ID_WIDTH-1:0]       rule_id,
    input  logic                           pmm_done,
    input  logic                           ctrl_en,
    input  logic [HDR_CNT_WIDTH-1:0]       hdr_words,
    output logic                           verdict_valid,
    input  logic                           verdict_ready,
    output logic [RULE_ID_WIDTH-2:0]       verdict_rule_id,
    output logic                           verdict_match,
    output logic [MATCH_CNT_WIDTH-1:0]     verdict_count,
    output logic [1:0]                     verdict_flags,
    output logic [31:0]                    stat_pkts,
    output logic [31:0]                    stat_match_pkts,
    output logic [31:0]                    stat_timeouts
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HDR_CNT_WIDTH-1:0]   BEAT_MAX  = {HDR_CNT_WIDTH{1'b1}};
    localparam logic [MATCH_CNT_WIDTH-1:0] MATCH_MAX = {MATCH_CNT_WIDTH{1'b1}};
    localparam logic [TO_W-1:0]            TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_WAIT, S_REPORT} state_t;

    state_t                     state, state_nxt;
    logic                       en_lat;
    logic [HDR_CNT_WIDTH-1:0]   hdr_lat;
    logic [HDR_CNT_WIDTH-1:0]   beat_cnt;
    logic [HDR_CNT_WIDTH-1:0]   beat_idx;
    logic                       payload_seen;
    logic [TO_W-1:0]            to_cnt;
    logic [MATCH_CNT_WIDTH-1:0] match_cnt;
    logic [RULE_ID_WIDTH-2:0]   first_id;
    logic [1:0]                 flags;

    logic in_idle, in_hdr, beat_acc, last_acc, pay_acc, match_hit, to_expired, verdict_hs;

    // Beat-0 index is forced to zero in IDLE so a stale count never leaks into a new packet
    assign in_idle    = (state == S_IDLE);
    assign beat_idx   = in_idle ? '0 : beat_cnt;
    assign in_hdr     = (beat_idx < hdr_lat);
    assign beat_acc   = s_axis_tvalid & s_axis_tready;
    assign last_acc   = beat_acc & s_axis_tlast;
    assign pay_acc    = beat_acc & ~in_hdr;
    assign match_hit  = ((state == S_PKT) || (state == S_WAIT)) & rule_id[RULE_ID_WIDTH-1];
    assign to_expired = (to_cnt == TO_LAST);
    assign verdict_hs = (state == S_REPORT) & verdict_ready;

    // State register
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= S_IDLE;
        else              state <= state_nxt;
    end

    // Next-state: header-only packets skip WAIT since the PMM never saw them
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_PKT: begin
                if (last_acc)      state_nxt = in_hdr ? S_REPORT : S_WAIT;
                else if (beat_acc) state_nxt = S_PKT;
            end
            S_WAIT:   if (pmm_done || to_expired) state_nxt = S_REPORT;
            S_REPORT: if (verdict_ready)          state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs: tready gated by the latched enable; verdict fields only visible in REPORT
    always_comb begin
        s_axis_tready   = en_lat & ((state == S_IDLE) || (state == S_PKT)) & (in_hdr | pmm_ready);
        verdict_valid   = (state == S_REPORT);
        verdict_rule_id = verdict_valid ? first_id : '0;
        verdict_match   = verdict_valid & (match_cnt != '0);
        verdict_count   = verdict_valid ? match_cnt : '0;
        verdict_flags   = verdict_valid ? flags : 2'b00;
    end

    // Config snapshot: tracks the registers while idle, frozen from the first accepted beat
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            en_lat  <= 1'b0;
            hdr_lat <= '0;
        end else if (in_idle && !beat_acc) begin
            en_lat  <= ctrl_en;
            hdr_lat <= hdr_words;
        end
    end

    // Beat counting and payload forwarding to the PMM with SOP/EOP framing
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            beat_cnt        <= '0;
            payload_seen    <= 1'b0;
            payload_in      <= '0;
            payload_valid   <= 1'b0;
            start_of_packet <= 1'b0;
            end_of_packet   <= 1'b0;
        end else begin
            if (beat_acc) beat_cnt <= (beat_idx == BEAT_MAX) ? BEAT_MAX : beat_idx + 1'b1;
            if (pay_acc) begin
                payload_in   <= s_axis_tdata;
                payload_seen <= 1'b1;
            end else if (verdict_hs) begin
                payload_seen <= 1'b0;
            end
            payload_valid   <= pay_acc;
            start_of_packet <= pay_acc & ~payload_seen;
            end_of_packet   <= pay_acc & s_axis_tlast;
        end
    end

    // Match collection, timeout counting and verdict flags; cleared on the verdict handshake
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            to_cnt    <= '0;
            match_cnt <= '0;
            first_id  <= '0;
            flags     <= 2'b00;
        end else begin
            to_cnt <= (state == S_WAIT) ? to_cnt + 1'b1 : '0;
            if (verdict_hs) begin
                match_cnt <= '0;
                first_id  <= '0;
                flags     <= 2'b00;
            end else begin
                if (match_hit) begin
                    if (match_cnt == '0)       first_id  <= rule_id[RULE_ID_WIDTH-2:0];
                    if (match_cnt != MATCH_MAX) match_cnt <= match_cnt + 1'b1;
                end
                if ((state == S_WAIT) && !pmm_done && to_expired) flags[0] <= 1'b1;
                if (last_acc && in_hdr)                           flags[1] <= 1'b1;
            end
        end
    end

`ifdef PMM_SCAN_STATS_EN
    // Wrapping per-verdict statistics
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            stat_pkts       <= '0;
            stat_match_pkts <= '0;
            stat_timeouts   <= '0;
        end else if (verdict_hs) begin
            stat_pkts <= stat_pkts + 32'd1;
            if (match_cnt != '0) stat_match_pkts <= stat_match_pkts + 32'd1;
            if (flags[0])        stat_timeouts   <= stat_timeouts + 32'd1;
        end
    end
`else
    assign stat_pkts       = '0;
    assign stat_match_pkts = '0;
    assign stat_timeouts   = '0;
`endif

endmodule
